apb_cmd_master: RTL and testbench
=================================

# apb_cmd_master

APB initiator that converts single-beat register commands from a local valid/ready command port into APB4 transfers. It drives the timer register slave (and any other APB responder on the same 12-bit peripheral bus) and returns read data and error status on a valid/ready response port. Exactly one transfer is outstanding at a time. A programmable wait-state timeout keeps the initiator from hanging on a non-responding slave.

## Interface
Parameters:
- ADDR_W, 12: APB address width.
- DATA_W, 32: APB data width; strobe width is DATA_W/8.
- TIMEOUT, 16: maximum ACCESS cycles with pready low before abort. 0 disables the timeout.
- TO_W, 8: wait counter width; must hold TIMEOUT.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  byte address.
- cmd_wdata  in  DATA_W  write data.
- cmd_strb  in  DATA_W/8  byte strobes; ignored for reads.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when high with rsp_valid.
- rsp_rdata  out  DATA_W  read data; 0 for writes and timeouts.
- rsp_err  out  1  pslverr sampled, or timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- pstrb  out  DATA_W/8  APB strobes.
- pready  in  1  APB ready.
- prdata  in  DATA_W  APB read data.
- pslverr  in  1  APB slave error.

## Operation
- FSM states IDLE, SETUP, ACCESS, RESP. Reset state IDLE.
- IDLE: cmd_ready=1. cmd_valid=1 captures write, addr, wdata, strb (strb forced to 0 for reads) into holding registers and moves to SETUP.
- SETUP: psel=1, penable=0. Always one cycle, then ACCESS.
- ACCESS: psel=1, penable=1.
  - pready=1: capture prdata (reads only; writes capture 0) and pslverr, then go to RESP.
  - pready=0: increment the wait counter. With TIMEOUT≠0 and counter == TIMEOUT-1, go to RESP with rsp_err=1, rsp_timeout=1, rdata=0.
- RESP: psel=penable=0. rsp_valid=1, response fields held stable. rsp_ready=1 returns to IDLE.
- paddr, pwrite, pwdata and pstrb come from the holding registers. They are stable from SETUP through the last ACCESS cycle. Outside SETUP/ACCESS they hold their last value; checkers ignore them there.
- The wait counter clears on entry to SETUP.
- cmd_ready is low in SETUP, ACCESS and RESP. Commands presented then are not accepted and must be held by the source.
- Reset values: cmd_ready=0 during reset and 1 from the first cycle after reset. psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, pstrb=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0.
- Reset in any state aborts the transfer: psel and penable drop on the next edge and no response is produced.

## Timing
- Command accepted at edge T: SETUP during cycle T+1, first ACCESS cycle T+2.
- Zero-wait slave (pready=1 at T+2): rsp_valid from T+3.
- The timer register slave returns pready one cycle after penable: ACCESS lasts 2 cycles and rsp_valid rises at T+4.
- Back-to-back throughput, zero-wait slave with rsp_ready tied high: one transfer per 4 cycles (IDLE, SETUP, ACCESS, RESP).
- Timeout: with pready held low, exactly TIMEOUT ACCESS cycles, then RESP. pready arriving in the final ACCESS cycle wins over the timeout (normal completion).
- pslverr, prdata and pready are sampled only in ACCESS. Values outside ACCESS are ignored.
- rsp_ready low in RESP stalls indefinitely. The APB bus stays idle (psel=0) during the stall.

## Test plan
- Write, slave pready one cycle after penable: cmd addr=0x00, wdata=0x0000_0101, strb=0xF. APB shows SETUP then 2 ACCESS cycles with paddr=0x00, pwdata=0x101, pstrb=0xF, pwrite=1. rsp_valid 4 cycles after accept, rsp_err=0, rsp_rdata=0.
- Read: cmd addr=0x0C, strb=0xF, slave returns prdata=0xFFFF_FFFF. pstrb=0 and pwrite=0 on the bus. rsp_rdata=0xFFFF_FFFF, rsp_err=0.
- Slave error: write to addr=0x00 with pslverr=1 alongside pready. rsp_err=1, rsp_timeout=0. The next command is accepted normally.
- Timeout, TIMEOUT=16, pready stuck low: exactly 16 ACCESS cycles, then psel=0 and rsp_err=1, rsp_timeout=1, rsp_rdata=0. A second test with pready=1 on ACCESS cycle 16 completes normally with rsp_timeout=0.
- Backpressure: rsp_ready held low for 10 cycles while cmd_valid stays high with a new command. rsp_valid and its fields are stable, cmd_ready=0, psel=0. The second command starts SETUP one cycle after the response handshake's IDLE cycle.
- Reset mid-ACCESS: assert rst for 1 cycle during ACCESS. All outputs take their reset values on the next edge, no rsp_valid pulse appears, and cmd_ready=1 on the first cycle after reset deasserts.

Source files
------------

// File: rtl/apb_cmd_master.sv
// apb_cmd_master: converts single-beat valid/ready register commands into
// APB4 transfers, one outstanding at a time, and returns the read data and
// error status on a valid/ready response port. A wait-state timeout aborts
// transfers to a slave that never raises pready.
module apb_cmd_master #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  // command port
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DATA_W-1:0]     cmd_wdata,
  input  logic [DATA_W/8-1:0]   cmd_strb,
  // response port
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  // APB4 initiator
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_W-1:0]     paddr,
  output logic [DATA_W-1:0]     pwdata,
  output logic [DATA_W/8-1:0]   pstrb,
  input  logic                  pready,
  input  logic [DATA_W-1:0]     prdata,
  input  logic                  pslverr
);

  localparam int STRB_W = DATA_W / 8;

  // Wait-counter value reached on the last permitted ACCESS cycle.
  localparam logic TO_EN = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t          state;
  logic [TO_W-1:0] wait_cnt;

  // Ready is held low while reset is asserted so no command is lost at the
  // reset edge, and rises in the very first cycle after reset drops.
  assign cmd_ready = (state == S_IDLE) && !rst;

  // Transfer sequencer: the APB signals and the response fields are all
  // registered here, so they change only on state transitions.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      pstrb       <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            // The APB address/data outputs double as the holding registers;
            // reads never drive strobes onto the bus.
            pwrite   <= cmd_write;
            paddr    <= cmd_addr;
            pwdata   <= cmd_wdata;
            pstrb    <= cmd_write ? cmd_strb : {STRB_W{1'b0}};
            psel     <= 1'b1;
            penable  <= 1'b0;
            wait_cnt <= '0;
            state    <= S_SETUP;
          end
        end

        S_SETUP: begin
          penable <= 1'b1;
          state   <= S_ACCESS;
        end

        S_ACCESS: begin
          // pready in the final permitted cycle takes priority over timeout.
          if (pready) begin
            rsp_rdata   <= pwrite ? {DATA_W{1'b0}} : prdata;
            rsp_err     <= pslverr;
            rsp_timeout <= 1'b0;
            rsp_valid   <= 1'b1;
            psel        <= 1'b0;
            penable     <= 1'b0;
            state       <= S_RESP;
          end else if (TO_EN && (wait_cnt == TO_LAST)) begin
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            psel        <= 1'b0;
            penable     <= 1'b0;
            state       <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed testbench for apb_cmd_master with hand-computed expectations.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_apb_cmd_master;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [11:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;

  int n_cmp = 0;
  int n_bad = 0;

  apb_cmd_master #(
    .ADDR_W (12),
    .DATA_W (32),
    .TIMEOUT(16),
    .TO_W   (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .cmd_strb   (cmd_strb),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rsp_timeout(rsp_timeout),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .paddr      (paddr),
    .pwdata     (pwdata),
    .pstrb      (pstrb),
    .pready     (pready),
    .prdata     (prdata),
    .pslverr    (pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just past the edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic wr, input logic [11:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_strb  = s;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL rst_cmd_ready got %b exp 0", cmd_ready); end
    n_cmp++; if (psel !== 1'b0) begin n_bad++; $display("FAIL rst_psel got %b exp 0", psel); end
    n_cmp++; if (penable !== 1'b0) begin n_bad++; $display("FAIL rst_penable got %b exp 0", penable); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_valid got %b exp 0", rsp_valid); end
    n_cmp++; if ({pwrite, paddr, pwdata, pstrb} !== 49'd0) begin n_bad++; $display("FAIL rst_apb_fields got %h exp 0", {pwrite, paddr, pwdata, pstrb}); end
    n_cmp++; if ({rsp_rdata, rsp_err, rsp_timeout} !== 34'd0) begin n_bad++; $display("FAIL rst_rsp_fields got %h exp 0", {rsp_rdata, rsp_err, rsp_timeout}); end
    rst = 1'b0;
    #1;
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_cmd_ready got %b exp 1", cmd_ready); end
  endtask

  // Timer-style slave: pready one cycle after penable, so ACCESS is 2 cycles.
  task automatic test_write;
    set_cmd(1'b1, 12'h000, 32'h0000_0101, 4'hF);
    pready = 1'b0;
    tick;  // accepted -> SETUP
    n_cmp++; if ({psel, penable} !== 2'b10) begin n_bad++; $display("FAIL wr_setup_sel_en got %b exp 10", {psel, penable}); end
    n_cmp++; if (paddr !== 12'h000) begin n_bad++; $display("FAIL wr_paddr got %h exp 000", paddr); end
    n_cmp++; if (pwdata !== 32'h0000_0101) begin n_bad++; $display("FAIL wr_pwdata got %h exp 00000101", pwdata); end
    n_cmp++; if (pstrb !== 4'hF) begin n_bad++; $display("FAIL wr_pstrb got %h exp f", pstrb); end
    n_cmp++; if (pwrite !== 1'b1) begin n_bad++; $display("FAIL wr_pwrite got %b exp 1", pwrite); end
    n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL wr_setup_cmd_ready got %b exp 0", cmd_ready); end
    cmd_valid = 1'b0;
    tick;  // ACCESS 1
    n_cmp++; if ({psel, penable} !== 2'b11) begin n_bad++; $display("FAIL wr_acc1_sel_en got %b exp 11", {psel, penable}); end
    tick;  // ACCESS 2
    n_cmp++; if ({psel, penable, rsp_valid} !== 3'b110) begin n_bad++; $display("FAIL wr_acc2_sel_en_vld got %b exp 110", {psel, penable, rsp_valid}); end
    n_cmp++; if (pwdata !== 32'h0000_0101) begin n_bad++; $display("FAIL wr_acc2_pwdata got %h exp 00000101", pwdata); end
    pready = 1'b1;
    prdata = 32'hDEAD_BEEF;
    tick;  // RESP, 4 cycles after accept
    n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL wr_rsp_valid got %b exp 1", rsp_valid); end
    n_cmp++; if (rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL wr_rsp_rdata got %h exp 0", rsp_rdata); end
    n_cmp++; if ({rsp_err, rsp_timeout} !== 2'b00) begin n_bad++; $display("FAIL wr_rsp_err got %b exp 00", {rsp_err, rsp_timeout}); end
    n_cmp++; if (psel !== 1'b0) begin n_bad++; $display("FAIL wr_rsp_psel got %b exp 0", psel); end
    pready = 1'b0;
    tick;  // IDLE
    n_cmp++; if ({rsp_valid, cmd_ready} !== 2'b01) begin n_bad++; $display("FAIL wr_idle_vld_rdy got %b exp 01", {rsp_valid, cmd_ready}); end
  endtask

  // Zero-wait read; pready raised early during SETUP must be ignored there.
  task automatic test_read;
    set_cmd(1'b0, 12'h00C, 32'h1234_5678, 4'hF);
    tick;  // SETUP
    n_cmp++; if (pwrite !== 1'b0) begin n_bad++; $display("FAIL rd_pwrite got %b exp 0", pwrite); end
    n_cmp++; if (pstrb !== 4'h0) begin n_bad++; $display("FAIL rd_pstrb got %h exp 0", pstrb); end
    n_cmp++; if (paddr !== 12'h00C) begin n_bad++; $display("FAIL rd_paddr got %h exp 00c", paddr); end
    cmd_valid = 1'b0;
    pready = 1'b1;
    prdata = 32'hFFFF_FFFF;
    tick;  // ACCESS
    n_cmp++; if ({psel, penable} !== 2'b11) begin n_bad++; $display("FAIL rd_acc_sel_en got %b exp 11", {psel, penable}); end
    tick;  // RESP
    n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL rd_rsp_valid got %b exp 1", rsp_valid); end
    n_cmp++; if (rsp_rdata !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL rd_rsp_rdata got %h exp ffffffff", rsp_rdata); end
    n_cmp++; if ({rsp_err, rsp_timeout} !== 2'b00) begin n_bad++; $display("FAIL rd_rsp_err got %b exp 00", {rsp_err, rsp_timeout}); end
    pready = 1'b0;
    tick;
  endtask

  task automatic test_slverr;
    set_cmd(1'b1, 12'h000, 32'h0000_0055, 4'h3);
    tick;  // SETUP
    cmd_valid = 1'b0;
    tick;  // ACCESS 1
    tick;  // ACCESS 2
    pready = 1'b1;
    pslverr = 1'b1;
    tick;  // RESP
    n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL err_rsp_valid got %b exp 1", rsp_valid); end
    n_cmp++; if ({rsp_err, rsp_timeout} !== 2'b10) begin n_bad++; $display("FAIL err_rsp_err_to got %b exp 10", {rsp_err, rsp_timeout}); end
    pready = 1'b0;
    pslverr = 1'b0;
    tick;  // IDLE
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL err_next_cmd_ready got %b exp 1", cmd_ready); end
    set_cmd(1'b0, 12'h004, 32'h0, 4'h0);
    tick;  // SETUP
    n_cmp++; if ({psel, penable, paddr} !== {2'b10, 12'h004}) begin n_bad++; $display("FAIL err_next_setup got %h exp 2004", {psel, penable, paddr}); end
    cmd_valid = 1'b0;
    pready = 1'b1;
    prdata = 32'h0000_00A5;
    tick;  // ACCESS
    tick;  // RESP
    n_cmp++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'h0000_00A5}) begin n_bad++; $display("FAIL err_next_rsp got %h exp 2000000a5", {rsp_valid, rsp_err, rsp_rdata}); end
    pready = 1'b0;
    tick;
  endtask

  task automatic test_timeout;
    int cycles;
    set_cmd(1'b1, 12'h008, 32'hCAFE_0001, 4'hF);
    pready = 1'b0;
    prdata = 32'h5A5A_5A5A;
    tick;  // SETUP
    cmd_valid = 1'b0;
    tick;  // ACCESS 1
    cycles = 0;
    while (psel && penable && cycles < 40) begin
      cycles++;
      tick;
    end
    n_cmp++; if (cycles !== 16) begin n_bad++; $display("FAIL to_access_cycles got %0d exp 16", cycles); end
    n_cmp++; if (psel !== 1'b0) begin n_bad++; $display("FAIL to_psel got %b exp 0", psel); end
    n_cmp++; if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b111) begin n_bad++; $display("FAIL to_rsp_flags got %b exp 111", {rsp_valid, rsp_err, rsp_timeout}); end
    n_cmp++; if (rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL to_rsp_rdata got %h exp 0", rsp_rdata); end
    tick;  // IDLE
  endtask

  // pready arrives in the 16th ACCESS cycle: normal completion wins.
  task automatic test_timeout_race;
    set_cmd(1'b0, 12'h004, 32'h0, 4'h0);
    pready = 1'b0;
    prdata = 32'h1234_5678;
    tick;  // SETUP
    cmd_valid = 1'b0;
    tick;  // ACCESS 1
    for (int i = 1; i < 16; i++) tick;  // ACCESS 16
    n_cmp++; if ({psel, penable, rsp_valid} !== 3'b110) begin n_bad++; $display("FAIL race_acc16 got %b exp 110", {psel, penable, rsp_valid}); end
    pready = 1'b1;
    tick;  // RESP
    n_cmp++; if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b100) begin n_bad++; $display("FAIL race_rsp_flags got %b exp 100", {rsp_valid, rsp_err, rsp_timeout}); end
    n_cmp++; if (rsp_rdata !== 32'h1234_5678) begin n_bad++; $display("FAIL race_rsp_rdata got %h exp 12345678", rsp_rdata); end
    pready = 1'b0;
    tick;
  endtask

  task automatic test_backpressure;
    rsp_ready = 1'b0;
    set_cmd(1'b1, 12'h010, 32'h0000_000A, 4'hF);
    pready = 1'b1;
    prdata = 32'h0000_0077;
    pslverr = 1'b0;
    tick;  // SETUP
    set_cmd(1'b0, 12'h014, 32'h0, 4'h0);  // second command, held by source
    tick;  // ACCESS
    tick;  // RESP
    for (int i = 0; i < 10; i++) begin
      n_cmp++; if ({rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== {3'b100, 32'h0}) begin n_bad++; $display("FAIL bp_rsp_hold[%0d] got %h exp 400000000", i, {rsp_valid, rsp_err, rsp_timeout, rsp_rdata}); end
      n_cmp++; if ({cmd_ready, psel} !== 2'b00) begin n_bad++; $display("FAIL bp_bus_idle[%0d] got %b exp 00", i, {cmd_ready, psel}); end
      tick;
    end
    rsp_ready = 1'b1;
    tick;  // handshake -> IDLE
    n_cmp++; if ({rsp_valid, cmd_ready, psel} !== 3'b010) begin n_bad++; $display("FAIL bp_idle got %b exp 010", {rsp_valid, cmd_ready, psel}); end
    tick;  // second command SETUP
    n_cmp++; if ({psel, penable, pwrite, paddr} !== {3'b100, 12'h014}) begin n_bad++; $display("FAIL bp_second_setup got %h exp 4014", {psel, penable, pwrite, paddr}); end
    cmd_valid = 1'b0;
    tick;  // ACCESS
    tick;  // RESP
    n_cmp++; if ({rsp_valid, rsp_rdata} !== {1'b1, 32'h0000_0077}) begin n_bad++; $display("FAIL bp_second_rsp got %h exp 100000077", {rsp_valid, rsp_rdata}); end
    pready = 1'b0;
    tick;
  endtask

  task automatic test_back_to_back;
    int accepts;
    int rsps;
    accepts = 0;
    rsps = 0;
    rsp_ready = 1'b1;
    pready = 1'b1;
    prdata = 32'h0000_0042;
    set_cmd(1'b0, 12'h020, 32'h0, 4'h0);
    for (int i = 0; i < 12; i++) begin
      if (cmd_ready && cmd_valid) accepts++;
      if (rsp_valid) rsps++;
      tick;
    end
    n_cmp++; if (accepts !== 3) begin n_bad++; $display("FAIL b2b_accepts got %0d exp 3", accepts); end
    n_cmp++; if (rsps !== 3) begin n_bad++; $display("FAIL b2b_responses got %0d exp 3", rsps); end
    cmd_valid = 1'b0;
    pready = 1'b0;
    tick;
  endtask

  task automatic test_reset_mid;
    set_cmd(1'b1, 12'h018, 32'h0000_00FF, 4'hF);
    pready = 1'b0;
    tick;  // SETUP
    cmd_valid = 1'b0;
    tick;  // ACCESS 1
    n_cmp++; if ({psel, penable} !== 2'b11) begin n_bad++; $display("FAIL mid_pre_access got %b exp 11", {psel, penable}); end
    rst = 1'b1;
    tick;
    n_cmp++; if ({psel, penable, rsp_valid, cmd_ready} !== 4'b0000) begin n_bad++; $display("FAIL mid_rst_ctrl got %b exp 0000", {psel, penable, rsp_valid, cmd_ready}); end
    n_cmp++; if ({pwrite, paddr, pwdata, pstrb} !== 49'd0) begin n_bad++; $display("FAIL mid_rst_apb_fields got %h exp 0", {pwrite, paddr, pwdata, pstrb}); end
    rst = 1'b0;
    #1;
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL mid_release_cmd_ready got %b exp 1", cmd_ready); end
    for (int i = 0; i < 3; i++) begin
      tick;
      n_cmp++; if ({rsp_valid, psel} !== 2'b00) begin n_bad++; $display("FAIL mid_no_rsp[%0d] got %b exp 00", i, {rsp_valid, psel}); end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr = '0;
    cmd_wdata = '0;
    cmd_strb = '0;
    rsp_ready = 1'b1;
    pready = 1'b0;
    prdata = '0;
    pslverr = 1'b0;
    test_reset;
    test_write;
    test_read;
    test_slverr;
    test_timeout;
    test_timeout_race;
    test_backpressure;
    test_back_to_back;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
